reply_seq: RTL

UART-side test responder and successor to the single-byte reply counter. When activated it:
- receives a COUNT_BYTES-wide little-endian byte count from the RX path;
- streams that many generated bytes to the TX path, with a programmable idle gap between bytes;
- supports four pattern modes and early abort on a configurable abort byte.

It sits between the UART RX/TX cores and the top-level command dispatcher, which raises activate and waits for done.

---
 rtl/reply_seq_pkg.sv | 31 +++
 rtl/reply_seq_gen.sv | 49 ++++
 rtl/reply_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reply_seq_pkg.sv
// Shared types and constants for the reply sequencer and its pattern generator.
package reply_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRecv,
    StGap,
    StSend,
    StWaitTx,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ModeInc,
    ModeDec,
    ModeAlt,
    ModeLfsr
  } mode_e;

  localparam logic [7:0] LfsrSeed = 8'h01;
  // Feedback taps for x^8+x^6+x^5+x^4+1, bit 7 is the x^8 stage.
  localparam logic [7:0] LfsrTaps = 8'hB8;
  localparam logic [7:0] AltA     = 8'h55;
  localparam logic [7:0] AltB     = 8'hAA;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LfsrTaps)};
  endfunction

endpackage

// File: rtl/reply_seq_gen.sv
// Pattern generator: loads a mode-dependent start value on init, advances on step.
module reply_seq_gen
  import reply_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       init_i,
  input  logic       step_i,
  input  mode_e      mode_i,
  output logic [7:0] value_o
);

  mode_e      mode_q, mode_d;
  logic [7:0] value_q, value_d;

  always_comb begin
    mode_d  = mode_q;
    value_d = value_q;
    if (init_i) begin
      mode_d = mode_i;
      case (mode_i)
        ModeInc: value_d = 8'h00;
        ModeDec: value_d = 8'hFF;
        ModeAlt: value_d = AltA;
        default: value_d = LfsrSeed;
      endcase
    end else if (step_i) begin
      case (mode_q)
        ModeInc: value_d = value_q + 8'd1;
        ModeDec: value_d = value_q - 8'd1;
        ModeAlt: value_d = (value_q == AltA) ? AltB : AltA;
        default: value_d = lfsr_next(value_q);
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q  <= ModeInc;
      value_q <= 8'h00;
    end else begin
      mode_q  <= mode_d;
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/reply_seq.sv
// Test responder: receives a byte count over RX, then streams generated bytes to TX
// with an idle gap before each byte, stopping early on the abort byte.
module reply_seq
  import reply_seq_pkg::*;
#(
  parameter int unsigned CountBytes = 1,
  parameter int unsigned GapCycles  = 5000000,
  parameter logic [7:0]  AbortByte  = 8'h55
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    activate_i,
  input  logic [1:0]              mode_i,
  output logic                    done_o,
  output logic                    aborted_o,
  output logic [8*CountBytes-1:0] sent_o,
  input  logic                    rx_ready_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    tx_active_i,
  input  logic                    tx_done_i,
  output logic                    tx_start_o,
  output logic [7:0]              tx_data_o
);

  localparam int unsigned CW   = 8 * CountBytes;
  localparam int unsigned GW   = $clog2(GapCycles + 1);
  localparam int unsigned IdxW = 2;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   sent_q, sent_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            abort_q, abort_d;
  logic            aborted_q, aborted_d;
  logic            done_q, done_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            gen_init, gen_step;
  logic [7:0]      gen_value;
  logic            abort_hit;

  reply_seq_gen u_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .init_i  (gen_init),
    .step_i  (gen_step),
    .mode_i  (mode_e'(mode_i)),
    .value_o (gen_value)
  );

  assign abort_hit = rx_ready_i && (rx_data_i == AbortByte) &&
                     (state_q inside {StGap, StSend, StWaitTx});

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sent_d    = sent_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    abort_d   = abort_q | abort_hit;
    aborted_d = aborted_q;
    tx_data_d = tx_data_q;
    gen_init  = 1'b0;
    gen_step  = 1'b0;

    case (state_q)
      StIdle: begin
        if (activate_i && !rx_ready_i) begin
          state_d   = StArm;
          count_d   = '0;
          sent_d    = '0;
          idx_d     = '0;
          abort_d   = 1'b0;
          aborted_d = 1'b0;
          gen_init  = 1'b1;
        end
      end
      StArm: state_d = StRecv;
      StRecv: begin
        if (rx_ready_i) begin
          for (int i = 0; i < int'(CountBytes); i++) begin
            if (idx_q == IdxW'(i)) count_d[8*i +: 8] = rx_data_i;
          end
          if (idx_q == IdxW'(CountBytes - 1)) begin
            state_d = (count_d == '0) ? StDone : StGap;
            gap_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (abort_d) begin
          state_d = StDone;
        end else if (gap_q == GW'(GapCycles - 1)) begin
          state_d   = StSend;
          tx_data_d = gen_value;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StSend: begin
        sent_d   = sent_q + 1'b1;
        gen_step = 1'b1;
        state_d  = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done_i) begin
          if ((sent_q == count_q) || abort_d) begin
            state_d = StDone;
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end
      end
      StDone: begin
        if (!activate_i && !rx_ready_i && !tx_active_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    tx_start_d = (state_d == StSend);
    done_d     = (state_d == StDone);
    if ((state_d == StDone) && (state_q != StDone)) aborted_d = abort_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      sent_q     <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      abort_q    <= 1'b0;
      aborted_q  <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      abort_q    <= abort_d;
      aborted_q  <= aborted_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign done_o     = done_q;
  assign aborted_o  = aborted_q;
  assign sent_o     = sent_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule
